ex_alu_stage: RTL and testbench
===============================

Name: ex_alu_stage

Overview:
- Execute-stage ALU for the pipelined RISC-V core.
- Consumes the 3-bit ALUControl code produced by the ALU decoder, together with two operands and a destination tag.
- Returns a registered result, zero flag and illegal-code flag.
- Valid/ready handshake on both sides, with a 2-entry buffer (main + skid) so that a downstream stall never loses an accepted operation.

Parameters:
WIDTH, 32, operand/result width in bits
RD_W, 5, destination register tag width

Ports:
clk  input  1  single clock, all state on rising edge
reset_n  input  1  asynchronous active-low reset
flush  input  1  synchronous pipeline flush; discards all held and incoming ops
in_valid  input  1  upstream op valid
in_ready  output  1  stage can accept an op this cycle
ALUControl  input  3  operation code
SrcA  input  WIDTH  operand A
SrcB  input  WIDTH  operand B
rd_in  input  RD_W  destination tag, carried unchanged
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result this cycle
ALUResult  output  WIDTH  registered result
Zero  output  1  ALUResult == 0
Illegal  output  1  op carried an undefined ALUControl code
rd_out  output  RD_W  destination tag of result

Behaviour:
- Reset, asynchronous on reset_n low:
  - out_valid=0, ALUResult=0, Zero=0, Illegal=0, rd_out=0.
  - Skid entry invalid; in_ready=1.
  - Asserting reset mid-operation drops all held ops.
- Operation encoding:
  - 000 add; 001 sub (A−B); 010 and; 011 or; 100 xor.
  - 101 slt: signed compare, result 1 if A<B else 0, zero-extended.
  - 110 and 111 are undefined: result 0, Illegal=1.
- Arithmetic is modulo 2^WIDTH with no overflow flag. Zero is computed from the result of the same op.
- Accept occurs on the cycle where in_valid && in_ready && !flush. Latency is one cycle: the result appears on the outputs the cycle after accept if the main entry was empty or drained that cycle.
- in_ready = !skid_valid. It is a registered signal with no combinational path from out_ready.
- Main entry drives the out_* ports. Per cycle, with drain = out_valid && out_ready:
  - drain and skid valid: main←skid, skid←accepted op if any, else skid invalid.
  - drain, skid empty: main←accepted op if any, else out_valid=0.
  - no drain, main empty: main←accepted op.
  - no drain, main full, accept: skid←accepted op (in_ready falls next cycle).
- Stability rule: while out_valid && !out_ready, ALUResult, Zero, Illegal and rd_out stay constant.
- Ordering: results leave in accept order; no reordering, duplication or drop except by flush or reset.
- Flush:
  - Next edge clears out_valid and skid; any same-cycle accept is discarded.
  - in_ready=1 the following cycle. Data registers may hold stale values, but out_valid=0.
- Simultaneous flush and drain: downstream takes the current result; nothing new is loaded.
- Maximum throughput is 1 op/cycle when out_ready is held high.

Test Plan:
- Reset then single ops, out_ready=1:
  - add 5+7 -> 12, Zero=0, one cycle later.
  - sub 9−9 -> 0, Zero=1.
  - slt with A=0xFFFFFFFF, B=1 -> 1.
  - and/or/xor with 0xF0F0F0F0, 0x0FF00FF0 -> 0x00F000F0 / 0xFFF0FFF0 / 0xFF00FF00.
- Undefined codes 110 and 111 -> ALUResult=0, Zero=1, Illegal=1, rd_out passes through.
- Back-pressure:
  - Stream ops rd=1..4 with out_ready=0 -> after 2 accepts in_ready=0, and outputs hold the rd=1 result.
  - Release out_ready -> rd=1..4 emerge in order with no gaps or duplicates.
- Full throughput: 16 random ops with in_valid=1 and out_ready=1 -> one result per cycle, each matching the golden model.
- Flush with both entries full and in_valid=1 -> next cycle out_valid=0 and in_ready=1; a subsequent op still emerges with correct 1-cycle latency.
- Assert reset_n low asynchronously between edges with ops held -> outputs go to 0 immediately; after release, normal operation resumes.

Source files
------------

// File: rtl/ex_alu_stage_if.sv
// Handshake bundle for the execute-stage ALU: operation request on the in_* side, result on the out_* side.
// The stage itself connects through the slave modport; the issuing/consuming pipeline uses master.
interface ex_alu_stage_if #(
    parameter int WIDTH = 32,
    parameter int RD_W  = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       ALUControl;
    logic [WIDTH-1:0] SrcA;
    logic [WIDTH-1:0] SrcB;
    logic [RD_W-1:0]  rd_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] ALUResult;
    logic             Zero;
    logic             Illegal;
    logic [RD_W-1:0]  rd_out;

    modport master (
        output in_valid, ALUControl, SrcA, SrcB, rd_in, out_ready,
        input  in_ready, out_valid, ALUResult, Zero, Illegal, rd_out
    );

    modport slave (
        input  in_valid, ALUControl, SrcA, SrcB, rd_in, out_ready,
        output in_ready, out_valid, ALUResult, Zero, Illegal, rd_out
    );
endinterface

// File: rtl/ex_alu_stage.sv
// Execute-stage ALU with a registered result and a two-entry (main + skid) output buffer,
// so downstream back-pressure never drops an accepted operation.
module ex_alu_stage #(
    parameter int WIDTH = 32,
    parameter int RD_W  = 5
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           flush,
    ex_alu_stage_if.slave  bus
);

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             zero;
        logic             ill;
        logic [RD_W-1:0]  rd;
    } entry_t;

    localparam entry_t ENTRY_RST = '{res: {WIDTH{1'b0}}, zero: 1'b0, ill: 1'b0, rd: {RD_W{1'b0}}};

    function automatic entry_t alu_op(input logic [2:0]       ctl,
                                      input logic [WIDTH-1:0] a,
                                      input logic [WIDTH-1:0] b,
                                      input logic [RD_W-1:0]  rd);
        entry_t e;
        e.rd  = rd;
        e.ill = 1'b0;
        case (ctl)
            3'b000:  e.res = a + b;
            3'b001:  e.res = a - b;
            3'b010:  e.res = a & b;
            3'b011:  e.res = a | b;
            3'b100:  e.res = a ^ b;
            3'b101:  e.res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            default: begin
                e.res = {WIDTH{1'b0}};
                e.ill = 1'b1;
            end
        endcase
        e.zero = (e.res == {WIDTH{1'b0}});
        return e;
    endfunction

    entry_t main_q, main_d;
    entry_t skid_q, skid_d;
    logic   main_valid_q, main_valid_d;
    logic   skid_valid_q, skid_valid_d;
    entry_t acc_s;
    logic   accept_s;
    logic   drain_s;

    // Buffer next-state: main drives the outputs, skid catches one op while main is stalled.
    always_comb begin
        acc_s        = alu_op(bus.ALUControl, bus.SrcA, bus.SrcB, bus.rd_in);
        accept_s     = bus.in_valid && !skid_valid_q && !flush;
        drain_s      = main_valid_q && bus.out_ready;
        main_d       = main_q;
        main_valid_d = main_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            // Data registers keep stale contents; only the valids matter.
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (drain_s && skid_valid_q) begin
            main_d       = skid_q;
            main_valid_d = 1'b1;
            skid_valid_d = accept_s;
            if (accept_s) begin
                skid_d = acc_s;
            end else begin
                skid_d = skid_q;
            end
        end else if (drain_s || !main_valid_q) begin
            main_valid_d = accept_s;
            if (accept_s) begin
                main_d = acc_s;
            end else begin
                main_d = main_q;
            end
        end else if (accept_s) begin
            skid_d       = acc_s;
            skid_valid_d = 1'b1;
        end else begin
            skid_valid_d = skid_valid_q;
        end
    end

    // Buffer state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            main_q       <= ENTRY_RST;
            skid_q       <= ENTRY_RST;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    // in_ready comes straight from a flop, so out_ready never reaches it combinationally.
    assign bus.in_ready  = !skid_valid_q;
    assign bus.out_valid = main_valid_q;
    assign bus.ALUResult = main_q.res;
    assign bus.Zero      = main_q.zero;
    assign bus.Illegal   = main_q.ill;
    assign bus.rd_out    = main_q.rd;

endmodule

// File: tb/tb_ex_alu_stage.sv
// Directed self-checking bench for ex_alu_stage: single ops, illegal codes, back-pressure,
// full throughput, flush and asynchronous reset.
module tb_ex_alu_stage;

    logic clk;
    logic reset_n;
    logic flush;
    int   errors;
    int   checks;

    ex_alu_stage_if #(.WIDTH(32), .RD_W(5)) bus ();

    ex_alu_stage #(.WIDTH(32), .RD_W(5)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (flush),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
        bus.in_valid   = 1'b1;
        bus.ALUControl = op;
        bus.SrcA       = a;
        bus.SrcB       = b;
        bus.rd_in      = rd;
    endtask

    // One op with out_ready high: result one cycle after accept, gone the cycle after.
    task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd, input logic [31:0] eres,
                         input logic ezero, input logic eill);
        @(negedge clk);
        drive(op, a, b, rd);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, "_res"},   bus.ALUResult,      eres);
        chk({tag, "_zero"},  32'(bus.Zero),      32'(ezero));
        chk({tag, "_ill"},   32'(bus.Illegal),   32'(eill));
        chk({tag, "_rd"},    32'(bus.rd_out),    32'(rd));
        @(negedge clk);
        chk({tag, "_gone"},  32'(bus.out_valid), 32'd0);
    endtask

    function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b, output logic ill);
        ill = 1'b0;
        if (op == 3'd0)      return a + b;
        else if (op == 3'd1) return a + ~b + 32'd1;
        else if (op == 3'd2) return a & b;
        else if (op == 3'd3) return a | b;
        else if (op == 3'd4) return a ^ b;
        else if (op == 3'd5) return (a[31] != b[31]) ? {31'd0, a[31]} : {31'd0, (a < b)};
        else begin
            ill = 1'b1;
            return 32'd0;
        end
    endfunction

    logic [31:0] bp_a   [4];
    logic [31:0] bp_b   [4];
    logic [31:0] bp_res [4];
    logic [2:0]  tp_op  [16];
    logic [31:0] tp_a   [16];
    logic [31:0] tp_b   [16];
    logic [31:0] tp_res [16];
    logic        tp_ill [16];

    initial begin
        int  pi;
        int  oi;
        bit  fire;
        errors         = 0;
        checks         = 0;
        reset_n        = 1'b0;
        flush          = 1'b0;
        bus.in_valid   = 1'b0;
        bus.ALUControl = 3'd0;
        bus.SrcA       = 32'd0;
        bus.SrcB       = 32'd0;
        bus.rd_in      = 5'd0;
        bus.out_ready  = 1'b1;

        #12;
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_res",   bus.ALUResult,      32'd0);
        chk("rst_zero",  32'(bus.Zero),      32'd0);
        chk("rst_ill",   32'(bus.Illegal),   32'd0);
        chk("rst_rd",    32'(bus.rd_out),    32'd0);
        chk("rst_ready", 32'(bus.in_ready),  32'd1);
        @(negedge clk);
        reset_n = 1'b1;

        do_op("add",    3'b000, 32'd5,        32'd7,        5'd3,  32'd12,       1'b0, 1'b0);
        do_op("sub",    3'b001, 32'd9,        32'd9,        5'd4,  32'd0,        1'b1, 1'b0);
        do_op("slt",    3'b101, 32'hFFFFFFFF, 32'd1,        5'd5,  32'd1,        1'b0, 1'b0);
        do_op("slt_n",  3'b101, 32'd1,        32'hFFFFFFFF, 5'd6,  32'd0,        1'b1, 1'b0);
        do_op("and",    3'b010, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd7,  32'h00F000F0, 1'b0, 1'b0);
        do_op("or",     3'b011, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd8,  32'hFFF0FFF0, 1'b0, 1'b0);
        do_op("xor",    3'b100, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd9,  32'hFF00FF00, 1'b0, 1'b0);
        do_op("addwrp", 3'b000, 32'hFFFFFFFF, 32'd1,        5'd10, 32'd0,        1'b1, 1'b0);
        do_op("ill110", 3'b110, 32'd5,        32'd3,        5'd17, 32'd0,        1'b1, 1'b1);
        do_op("ill111", 3'b111, 32'hFFFF0000, 32'h1234,     5'd30, 32'd0,        1'b1, 1'b1);

        // Back-pressure: two accepts fill main+skid, then in_ready drops.
        bp_a[0] = 32'h100; bp_b[0] = 32'd1; bp_res[0] = 32'h101;
        bp_a[1] = 32'h200; bp_b[1] = 32'd2; bp_res[1] = 32'h202;
        bp_a[2] = 32'h300; bp_b[2] = 32'd3; bp_res[2] = 32'h303;
        bp_a[3] = 32'h400; bp_b[3] = 32'd4; bp_res[3] = 32'h404;
        @(negedge clk);
        bus.out_ready = 1'b0;
        drive(3'b000, bp_a[0], bp_b[0], 5'd1);
        @(negedge clk);
        chk("bp_ready1", 32'(bus.in_ready), 32'd1);
        drive(3'b000, bp_a[1], bp_b[1], 5'd2);
        @(negedge clk);
        chk("bp_ready2", 32'(bus.in_ready),  32'd0);
        chk("bp_valid",  32'(bus.out_valid), 32'd1);
        chk("bp_rd",     32'(bus.rd_out),    32'd1);
        chk("bp_res",    bus.ALUResult,      32'h101);
        drive(3'b000, bp_a[2], bp_b[2], 5'd3);
        @(negedge clk);
        chk("bp_hold_ready", 32'(bus.in_ready), 32'd0);
        chk("bp_hold_rd",    32'(bus.rd_out),   32'd1);
        chk("bp_hold_res",   bus.ALUResult,     32'h101);
        chk("bp_hold_zero",  32'(bus.Zero),     32'd0);
        bus.out_ready = 1'b1;
        pi = 2;
        oi = 0;
        for (int cyc = 0; cyc < 20 && oi < 4; cyc++) begin
            chk("bp_nogap", 32'(bus.out_valid), 32'd1);
            if (bus.out_valid) begin
                chk("bp_order_rd",  32'(bus.rd_out), 32'(oi + 1));
                chk("bp_order_res", bus.ALUResult,   bp_res[oi]);
                oi++;
            end
            fire = bus.in_valid && bus.in_ready;
            @(negedge clk);
            if (fire) begin
                pi++;
                if (pi < 4) drive(3'b000, bp_a[pi], bp_b[pi], 5'(pi + 1));
                else        bus.in_valid = 1'b0;
            end
        end
        chk("bp_count", 32'(oi), 32'd4);
        chk("bp_nodup", 32'(bus.out_valid), 32'd0);

        // Full throughput: one op in and one result out every cycle.
        for (int i = 0; i < 16; i++) begin
            tp_op[i]  = 3'($urandom_range(0, 7));
            tp_a[i]   = $urandom;
            tp_b[i]   = (i % 5 == 0) ? tp_a[i] : $urandom;
            tp_res[i] = ref_alu(tp_op[i], tp_a[i], tp_b[i], tp_ill[i]);
        end
        for (int t = 0; t <= 16; t++) begin
            if (t > 0) begin
                chk("tp_valid", 32'(bus.out_valid), 32'd1);
                chk("tp_res",   bus.ALUResult,      tp_res[t-1]);
                chk("tp_zero",  32'(bus.Zero),      32'(tp_res[t-1] == 32'd0));
                chk("tp_ill",   32'(bus.Illegal),   32'(tp_ill[t-1]));
                chk("tp_rd",    32'(bus.rd_out),    32'(t - 1));
            end
            if (t < 16) begin
                chk("tp_ready", 32'(bus.in_ready), 32'd1);
                drive(tp_op[t], tp_a[t], tp_b[t], 5'(t));
            end else begin
                bus.in_valid = 1'b0;
            end
            @(negedge clk);
        end
        chk("tp_end", 32'(bus.out_valid), 32'd0);

        // Flush with both entries full and a new op offered.
        bus.out_ready = 1'b0;
        drive(3'b000, 32'd1, 32'd2, 5'd5);
        @(negedge clk);
        drive(3'b001, 32'd10, 32'd3, 5'd6);
        @(negedge clk);
        chk("fl_full_ready", 32'(bus.in_ready),  32'd0);
        chk("fl_full_valid", 32'(bus.out_valid), 32'd1);
        drive(3'b011, 32'd4, 32'd8, 5'd7);
        flush = 1'b1;
        @(negedge clk);
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        chk("fl_valid", 32'(bus.out_valid), 32'd0);
        chk("fl_ready", 32'(bus.in_ready),  32'd1);

        // Flush while an accept would otherwise land in the skid entry.
        drive(3'b000, 32'd3, 32'd3, 5'd8);
        @(negedge clk);
        drive(3'b000, 32'd6, 32'd6, 5'd9);
        flush = 1'b1;
        @(negedge clk);
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        chk("fl2_valid", 32'(bus.out_valid), 32'd0);
        chk("fl2_ready", 32'(bus.in_ready),  32'd1);
        @(negedge clk);
        chk("fl2_still_empty", 32'(bus.out_valid), 32'd0);

        // Flush on the same cycle the downstream drains main.
        drive(3'b000, 32'd20, 32'd1, 5'd12);
        @(negedge clk);
        bus.out_ready = 1'b1;
        chk("fd_valid_before", 32'(bus.out_valid), 32'd1);
        drive(3'b000, 32'd30, 32'd1, 5'd13);
        flush = 1'b1;
        @(negedge clk);
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        chk("fd_valid", 32'(bus.out_valid), 32'd0);
        chk("fd_ready", 32'(bus.in_ready),  32'd1);

        do_op("post_flush", 3'b100, 32'hA5A5A5A5, 32'hFFFFFFFF, 5'd11, 32'h5A5A5A5A, 1'b0, 1'b0);

        // Asynchronous reset between edges with both entries occupied.
        @(negedge clk);
        bus.out_ready = 1'b0;
        drive(3'b000, 32'h10, 32'h20, 5'd20);
        @(negedge clk);
        drive(3'b000, 32'h30, 32'h40, 5'd21);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("ar_held_valid", 32'(bus.out_valid), 32'd1);
        chk("ar_held_res",   bus.ALUResult,      32'h30);
        #2;
        reset_n = 1'b0;
        #1;
        chk("ar_valid", 32'(bus.out_valid), 32'd0);
        chk("ar_res",   bus.ALUResult,      32'd0);
        chk("ar_rd",    32'(bus.rd_out),    32'd0);
        chk("ar_zero",  32'(bus.Zero),      32'd0);
        chk("ar_ill",   32'(bus.Illegal),   32'd0);
        chk("ar_ready", 32'(bus.in_ready),  32'd1);
        @(negedge clk);
        reset_n       = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("ar_no_stale", 32'(bus.out_valid), 32'd0);
        do_op("after_rst", 3'b011, 32'h0000FF00, 32'h000000FF, 5'd22, 32'h0000FFFF, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
